// File: rtl/rs_bm_scheduler.sv
// rs_bm_scheduler: round-robin share of one 16-symbol GF(256) BM engine
// among NUM_CH syndrome channels; returns locator + channel id on valid/ready.
//
// Ports:
//   clk, rst_n                clock, async active-low reset
//   req_valid/req_ready       per-channel request; req_ready one-hot grant pulse
//   req_syn                   channel c syndromes at [c*SYN_W +: SYN_W]
//   bm_data_in/bm_valid_in    syndromes and one-cycle start to the engine
//   bm_poly_out/bm_valid_out  engine result and done pulse
//   bm_busy                   engine running (blocks new grants)
//   rsp_valid/rsp_ready       response handshake
//   rsp_poly/rsp_ch/rsp_err   locator polynomial, channel id, watchdog error
//
// Optional feature: define RS_BM_WATCHDOG_EN to bound WAIT to TIMEOUT cycles;
// expiry returns rsp_err = 1 with a zero polynomial.

module rs_bm_scheduler #(
    parameter int NUM_CH  = 4,
    parameter int SYN_W   = 128,
    parameter int TIMEOUT = 64,
    localparam int CH_W   = $clog2(NUM_CH)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [NUM_CH-1:0]       req_valid,
    output logic [NUM_CH-1:0]       req_ready,
    input  logic [NUM_CH*SYN_W-1:0] req_syn,
    output logic [SYN_W-1:0]        bm_data_in,
    output logic                    bm_valid_in,
    input  logic [SYN_W-1:0]        bm_poly_out,
    input  logic                    bm_valid_out,
    input  logic                    bm_busy,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [SYN_W-1:0]        rsp_poly,
    output logic [CH_W-1:0]         rsp_ch,
    output logic                    rsp_err
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_HOLD  = 2'd3;

    logic [1:0]       r_state;
    logic [CH_W-1:0]  r_rr;
    logic [CH_W-1:0]  r_ch;
    logic [SYN_W-1:0] r_syn;
    logic [SYN_W-1:0] r_poly;

    logic             w_found;
    logic [CH_W-1:0]  w_gnt;
    logic [CH_W-1:0]  w_idx;
    logic [SYN_W-1:0] w_gsyn;
    logic             w_take;

    // Round-robin search starting at r_rr, wrapping at NUM_CH-1.
    always_comb begin
        w_found = 1'b0;
        w_gnt   = '0;
        w_idx   = r_rr;
        for (int i = 0; i < NUM_CH; i++) begin
            if (!w_found && req_valid[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
            w_idx = (w_idx == CH_W'(NUM_CH - 1)) ? '0 : w_idx + 1'b1;
        end
    end

    always_comb begin
        w_gsyn = '0;
        for (int c = 0; c < NUM_CH; c++) begin
            if (w_gnt == CH_W'(c)) begin
                w_gsyn = req_syn[c*SYN_W +: SYN_W];
            end
        end
    end

    assign w_take    = (r_state == S_IDLE) && w_found && !bm_busy;
    assign req_ready = w_take ? (NUM_CH'(1) << w_gnt) : '0;

    assign bm_valid_in = (r_state == S_ISSUE);
    assign bm_data_in  = r_syn;
    assign rsp_valid   = (r_state == S_HOLD);
    assign rsp_poly    = r_poly;
    assign rsp_ch      = r_ch;

`ifdef RS_BM_WATCHDOG_EN
    logic [7:0] r_wd;
    logic       r_err;
    assign rsp_err = r_err;
`else
    assign rsp_err = 1'b0;
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_rr    <= '0;
            r_ch    <= '0;
            r_syn   <= '0;
            r_poly  <= '0;
`ifdef RS_BM_WATCHDOG_EN
            r_wd    <= '0;
            r_err   <= 1'b0;
`endif
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_take) begin
                        r_syn <= w_gsyn;
                        r_ch  <= w_gnt;
                        // Zero syndrome means no errors: C(x) = 1, skip the engine.
                        if (w_gsyn == '0) begin
                            r_poly  <= SYN_W'(1);
`ifdef RS_BM_WATCHDOG_EN
                            r_err   <= 1'b0;
`endif
                            r_state <= S_HOLD;
                        end else begin
                            r_state <= S_ISSUE;
                        end
                    end
                end
                S_ISSUE: begin
`ifdef RS_BM_WATCHDOG_EN
                    r_wd    <= '0;
`endif
                    r_state <= S_WAIT;
                end
                S_WAIT: begin
                    if (bm_valid_out) begin
                        r_poly  <= bm_poly_out;
`ifdef RS_BM_WATCHDOG_EN
                        r_err   <= 1'b0;
`endif
                        r_state <= S_HOLD;
                    end
`ifdef RS_BM_WATCHDOG_EN
                    else if (r_wd == 8'(TIMEOUT - 1)) begin
                        r_poly  <= '0;
                        r_err   <= 1'b1;
                        r_state <= S_HOLD;
                    end else begin
                        r_wd <= r_wd + 8'd1;
                    end
`endif
                end
                S_HOLD: begin
                    if (rsp_ready) begin
                        r_rr    <= (r_ch == CH_W'(NUM_CH - 1)) ? '0 : r_ch + 1'b1;
                        r_state <= S_IDLE;
                    end
                end
                default: r_state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_rs_bm_scheduler.sv
// tb_rs_bm_scheduler: directed bench for rs_bm_scheduler (NUM_CH = 4)
// with a fixed-latency engine stand-in whose result is a known function of its input.

module tb_rs_bm_scheduler;

    localparam int NCH = 4;
    localparam int SW  = 128;
    localparam int LAT = 4;
    // Engine done pulse arrives LAT+1 cycles after the start pulse.
    localparam int EXP_LAT = 1 + (LAT + 1) + 1;

    logic            clk;
    logic            rst_n;
    logic [NCH-1:0]  req_valid;
    logic [NCH-1:0]  req_ready;
    logic [NCH*SW-1:0] req_syn;
    logic [SW-1:0]   bm_data_in;
    logic            bm_valid_in;
    logic [SW-1:0]   bm_poly_out;
    logic            bm_valid_out;
    logic            bm_busy;
    logic            rsp_valid;
    logic            rsp_ready;
    logic [SW-1:0]   rsp_poly;
    logic [1:0]      rsp_ch;
    logic            rsp_err;

    logic [SW-1:0] tb_syn [NCH];
    logic          tb_silent;
    logic          tb_busy_force;
    logic          tb_spur;

    int n_vec;
    int n_err;

    assign req_syn = {tb_syn[3], tb_syn[2], tb_syn[1], tb_syn[0]};

    rs_bm_scheduler #(
        .NUM_CH (NCH),
        .SYN_W  (SW),
        .TIMEOUT(64)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .req_valid   (req_valid),
        .req_ready   (req_ready),
        .req_syn     (req_syn),
        .bm_data_in  (bm_data_in),
        .bm_valid_in (bm_valid_in),
        .bm_poly_out (bm_poly_out),
        .bm_valid_out(bm_valid_out),
        .bm_busy     (bm_busy),
        .rsp_valid   (rsp_valid),
        .rsp_ready   (rsp_ready),
        .rsp_poly    (rsp_poly),
        .rsp_ch      (rsp_ch),
        .rsp_err     (rsp_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [SW-1:0] eng_f(input logic [SW-1:0] s);
        return {s[119:0], s[127:120]} ^ 128'h0F1E2D3C4B5A69788796A5B4C3D2E1F0;
    endfunction

    // Engine stand-in
    logic [3:0]    e_cnt;
    logic          e_busy;
    logic          e_done;
    logic [SW-1:0] e_data;
    logic [SW-1:0] e_poly;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            e_cnt  <= '0;
            e_busy <= 1'b0;
            e_done <= 1'b0;
            e_data <= '0;
            e_poly <= '0;
        end else begin
            e_done <= 1'b0;
            if (bm_valid_in) begin
                e_busy <= 1'b1;
                e_cnt  <= 4'(LAT);
                e_data <= bm_data_in;
            end else if (e_busy) begin
                if (e_cnt == 4'd1) begin
                    e_busy <= 1'b0;
                    e_done <= !tb_silent;
                    e_poly <= eng_f(e_data);
                end else begin
                    e_cnt <= e_cnt - 4'd1;
                end
            end
        end
    end

    assign bm_busy      = e_busy | tb_busy_force;
    assign bm_valid_out = e_done | tb_spur;
    assign bm_poly_out  = e_poly;

    task automatic chk(input string name, input logic [SW-1:0] act,
                       input logic [SW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One full transaction from the IDLE cycle; called at a falling edge.
    task automatic serve(input logic [3:0] mask, input int exp_ch,
                         input bit bypass, input int hold);
        logic [SW-1:0] exp_poly;
        logic [SW-1:0] p0;
        logic [1:0]    c0;
        int            w;
        int            lat;
        int            nst;
        bit            stable;
        bit            blocked;
        exp_poly  = bypass ? 128'h1 : eng_f(tb_syn[exp_ch]);
        rsp_ready = (hold == 0);
        req_valid = mask;
        #1;
        w = 0;
        while (req_ready == 4'b0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("grant", SW'(req_ready), SW'(4'b1 << exp_ch));
        if (req_ready == 4'b0) return;
        @(negedge clk);
        req_valid = '0;
        #1;
        lat = 1;
        nst = 0;
        while (!rsp_valid && lat < 200) begin
            if (bm_valid_in) begin
                nst++;
                chk("bm_data_in", bm_data_in, tb_syn[exp_ch]);
            end
            @(negedge clk); #1; lat++;
        end
        chk("rsp_valid", SW'(rsp_valid), SW'(1));
        chk("latency", SW'(lat), SW'(bypass ? 1 : EXP_LAT));
        chk("starts", SW'(nst), SW'(bypass ? 0 : 1));
        chk("rsp_ch", SW'(rsp_ch), SW'(exp_ch));
        chk("rsp_poly", rsp_poly, exp_poly);
        chk("rsp_err", SW'(rsp_err), SW'(0));
        if (hold > 0) begin
            p0        = rsp_poly;
            c0        = rsp_ch;
            stable    = 1'b1;
            blocked   = 1'b1;
            req_valid = 4'hF;
            for (int k = 0; k < hold; k++) begin
                @(negedge clk); #1;
                if (!rsp_valid || rsp_poly !== p0 || rsp_ch !== c0 || rsp_err)
                    stable = 1'b0;
                if (req_ready != 4'b0) blocked = 1'b0;
            end
            chk("hold_stable", SW'(stable), SW'(1));
            chk("hold_no_ready", SW'(blocked), SW'(1));
            rsp_ready = 1'b1;
        end
    endtask

    typedef struct {
        logic [3:0] mask;
        int         ch;
    } vec_t;

    initial begin
        vec_t tbl [10];
        int   w;
        bit   blocked;

        n_vec = 0;
        n_err = 0;
        tbl[0] = '{4'b1010, 1};
        tbl[1] = '{4'b1000, 3};
        tbl[2] = '{4'b1111, 0};
        tbl[3] = '{4'b1111, 1};
        tbl[4] = '{4'b1111, 2};
        tbl[5] = '{4'b1111, 3};
        tbl[6] = '{4'b0100, 2};
        tbl[7] = '{4'b0011, 0};
        tbl[8] = '{4'b0010, 1};
        tbl[9] = '{4'b1001, 3};

        tb_syn[0] = 128'h11223344556677889900AABBCCDDEEFF;
        tb_syn[1] = 128'hDEADBEEF0123456789ABCDEF00000001;
        tb_syn[2] = 128'h00000000000000000000000000000203;
        tb_syn[3] = 128'h80000000000000000000000000C0FFEE;
        tb_silent     = 1'b0;
        tb_busy_force = 1'b0;
        tb_spur       = 1'b0;
        req_valid     = '0;
        rsp_ready     = 1'b1;
        rst_n         = 1'b0;

        repeat (3) @(negedge clk);
        #1;
        chk("rst_req_ready", SW'(req_ready), SW'(0));
        chk("rst_bm_valid_in", SW'(bm_valid_in), SW'(0));
        chk("rst_bm_data_in", bm_data_in, SW'(0));
        chk("rst_rsp_valid", SW'(rsp_valid), SW'(0));
        chk("rst_rsp_poly", rsp_poly, SW'(0));
        chk("rst_rsp_ch", SW'(rsp_ch), SW'(0));
        chk("rst_rsp_err", SW'(rsp_err), SW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 10; i++) begin
            serve(tbl[i].mask, tbl[i].ch, 1'b0, 0);
            @(negedge clk);
        end

        // Zero syndrome: bypass straight to HOLD with C(x) = 1.
        tb_syn[0] = '0;
        serve(4'b0001, 0, 1'b1, 0);
        @(negedge clk);
        tb_syn[0] = 128'h11223344556677889900AABBCCDDEEFF;

        // Stray engine done in IDLE must not produce a response.
        tb_spur = 1'b1;
        @(negedge clk);
        tb_spur = 1'b0;
        #1;
        chk("spur_rsp_valid", SW'(rsp_valid), SW'(0));
        @(negedge clk); #1;
        chk("spur_no_start", SW'(bm_valid_in), SW'(0));

        // Engine busy in IDLE blocks grants; ch1 withdraws, so ch0 wins by wrap.
        @(negedge clk);
        tb_busy_force = 1'b1;
        req_valid     = 4'b0011;
        blocked       = 1'b1;
        for (int k = 0; k < 5; k++) begin
            @(negedge clk); #1;
            if (req_ready != 4'b0) blocked = 1'b0;
        end
        chk("busy_no_grant", SW'(blocked), SW'(1));
        @(negedge clk);
        tb_busy_force = 1'b0;
        serve(4'b0001, 0, 1'b0, 0);
        @(negedge clk);

        // Back-pressure for 20 cycles, then immediate regrant of next channel.
        serve(4'b0010, 1, 1'b0, 20);
        @(negedge clk);
        serve(4'hF, 2, 1'b0, 0);
        @(negedge clk);

        // Reset pulse while waiting on the engine.
        req_valid = 4'b0010;
        rsp_ready = 1'b1;
        #1;
        w = 0;
        while (req_ready == 4'b0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("rstw_grant", SW'(req_ready), SW'(4'b0010));
        @(negedge clk);
        req_valid = '0;
        #1;
        chk("rstw_start", SW'(bm_valid_in), SW'(1));
        @(negedge clk);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        chk("rstw_rsp_valid", SW'(rsp_valid), SW'(0));
        chk("rstw_bm_data_in", bm_data_in, SW'(0));
        chk("rstw_rsp_ch", SW'(rsp_ch), SW'(0));
        chk("rstw_rsp_poly", rsp_poly, SW'(0));
        chk("rstw_bm_valid_in", SW'(bm_valid_in), SW'(0));
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        serve(4'b1010, 1, 1'b0, 0);
        @(negedge clk);

`ifdef RS_BM_WATCHDOG_EN
        // Silent engine: watchdog expires after 64 WAIT cycles.
        tb_silent = 1'b1;
        req_valid = 4'b0100;
        #1;
        w = 0;
        while (req_ready == 4'b0 && w < 20) begin
            @(negedge clk); #1; w++;
        end
        chk("wd_grant", SW'(req_ready), SW'(4'b0100));
        @(negedge clk);
        req_valid = '0;
        #1;
        w = 1;
        while (!rsp_valid && w < 300) begin
            @(negedge clk); #1; w++;
        end
        chk("wd_latency", SW'(w), SW'(1 + 64 + 1));
        chk("wd_rsp_err", SW'(rsp_err), SW'(1));
        chk("wd_rsp_poly", rsp_poly, SW'(0));
        chk("wd_rsp_ch", SW'(rsp_ch), SW'(2));
        @(negedge clk);
        tb_silent = 1'b0;
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
